// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the cotm32 elastic pipeline stages.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0), used to build bubble payloads.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear, shared by performance monitors.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage: optional two-entry skid buffer, bubble
// insertion on reset/flush/drain, and a saturating back-pressure counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W = 128,
  parameter int                FLAG_W = 8,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [FLAG_W-1:0] o_flags,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_bp_cnt
);

  pipe_state_e       state;
  logic [DATA_W-1:0] main_data;
  logic [FLAG_W-1:0] main_flags;
  logic [DATA_W-1:0] skid_data;
  logic [FLAG_W-1:0] skid_flags;
  logic              acc;
  logic              ret;

  assign o_valid = (state != EMPTY);
  assign o_full  = (state == FULL);
  assign o_data  = main_data;
  assign o_flags = main_flags;

  // With the skid entry, ready depends only on local state, cutting the
  // downstream-to-upstream combinational path.
  assign o_ready = SKID ? (state != FULL) : (!o_valid || i_ready);

  assign acc = i_valid && o_ready && !i_flush;
  assign ret = o_valid && i_ready;

  // NOTE: payload registers are reset too, because an empty stage must present
  // BUBBLE and zero flags rather than stale or unknown contents.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state      <= EMPTY;
      main_data  <= BUBBLE;
      main_flags <= '0;
      skid_data  <= BUBBLE;
      skid_flags <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state      <= HALF;
            main_data  <= i_data;
            main_flags <= i_flags;
          end
        end
        HALF: begin
          if (acc && !ret) begin
            state      <= FULL;
            skid_data  <= i_data;
            skid_flags <= i_flags;
          end else if (ret && !acc) begin
            state      <= EMPTY;
            main_data  <= BUBBLE;
            main_flags <= '0;
          end else if (acc && ret) begin
            main_data  <= i_data;
            main_flags <= i_flags;
          end
        end
        FULL: begin
          if (ret) begin
            state      <= HALF;
            main_data  <= skid_data;
            main_flags <= skid_flags;
            skid_data  <= BUBBLE;
            skid_flags <= '0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_bp_cnt (
    .i_clk  (i_clk),
    .i_clear(i_rst),
    .i_inc  (o_valid && !i_ready),
    .o_count(o_bp_cnt)
  );

endmodule
